cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Shared compare/subtract unit arbiter. Up to NREQ requesters (ALU lanes, branch unit, address-check logic) time-share one W-bit subtractor-based compare datapath under round-robin arbitration. Results return through a 2-entry response FIFO tagged with the requester id. Compare results are bit-compatible with the processor's existing slt/sgt units.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 32: operand/result width
- IDW, $clog2(NREQ): id width (derived)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*W  operand A; lane i = bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_op  in  NREQ*2  op per lane: 00 SLT, 01 SGT, 10 SUB, 11 SLTU
- rsp_valid  out  1  response FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  IDW  requester index of head
- rsp_data  out  W  result of head
- rsp_err  out  1  head op was unsupported

## Operation
- Datapath: one subtractor computes D = (A − B) mod 2^W and borrow BO = (A < B unsigned).
- SLT: rsp_data = {0…, D[W−1]}. No overflow correction; sign of wrapped difference only.
- SGT: operands swapped, D' = B − A; rsp_data = {0…, D'[W−1]}.
- SUB: rsp_data = D.
- SLTU: see Configuration.
- Arbitration: round-robin pointer `ptr`. Search starts at index ptr, wraps modulo NREQ; first lane with req_valid wins. After grant to lane g, ptr ← (g+1) mod NREQ. No grant → ptr unchanged.
- Grant condition: at most one grant per cycle; only when can_push = (count < 2) || (rsp_valid && rsp_ready).
- req_ready[g] is combinational from req_valid, ptr, and can_push. A transfer occurs when req_valid[g] && req_ready[g].
- Granted lane's operands/op are evaluated in the same cycle. The result is pushed into the FIFO at the clock edge.
- FIFO: 2 entries {id, data, err}, count ∈ {0,1,2}. Push and pop in the same cycle leave count unchanged, including at count = 2.
- Head outputs are stable while rsp_valid && !rsp_ready.
- Requester protocol: req_a/req_b/req_op are held stable while req_valid && !req_ready. Requesters do not retract req_valid before a grant; the block does not check this.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, count = 0, ptr = 0.
- Latency: a grant at edge N makes the result visible on rsp_valid after edge N when the FIFO was empty or held one entry. With count = 2 and a pop, the result is the second entry.
- Throughput: 1 op/cycle sustained while rsp_ready stays high.
- Full (count = 2, rsp_ready = 0): all req_ready = 0; ptr frozen.
- Empty: rsp_valid = 0; rsp_id/rsp_data/rsp_err hold their last values, 0 after reset.
- Reset mid-operation: FIFO contents and pending grants are discarded. No response is produced for an op granted in the cycle rst_n falls.
- rst_n deassertion is synchronised externally; first grant is possible on the first edge after release.

## Configuration
- Macro `CMP_ARB_UNSIGNED_EN`.
- Defined: op 11 = SLTU, rsp_data = {0…, BO}, rsp_err = 0.
- Undefined: op 11 is still granted and consumes a FIFO slot; rsp_data = 0, rsp_err = 1. Ops 00/01/10 are unaffected.

## Test plan
- Single SLT, lane 0, A=5, B=9, rsp_ready=1 → grant in cycle 0; cycle 1: rsp_valid=1, rsp_id=0, rsp_data=1. SGT with same operands → 0.
- Wrap quirk: SLT with A=0x7FFFFFFF, B=0xFFFFFFFF → D=0x80000000, rsp_data=1. SUB with A=0, B=1 → 0xFFFFFFFF.
- Round-robin: all 4 lanes valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,… with exactly one req_ready high per cycle.
- Backpressure: rsp_ready=0 with lanes 1 and 2 valid → two grants, then count=2 and req_ready=0. Raise rsp_ready → pop lane 1 result and grant next in the same cycle; count stays 2.
- Op 11 with A=1, B=2 → rsp_data=1, rsp_err=0 with CMP_ARB_UNSIGNED_EN; rsp_data=0, rsp_err=1 without it.
- Reset with count=2 and lane 3 pending → all outputs 0 immediately (asynchronous). After release, the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: request/response bundle between the requesters and the
// shared compare unit. The requester side uses the master modport and the
// arbiter uses the slave modport.
//
// Handshake rules (valid/ready):
//   - Request lane i transfers on a rising edge where req_valid[i] && req_ready[i].
//     While req_valid[i] && !req_ready[i], req_a/req_b/req_op of that lane
//     are held stable, and req_valid[i] is not withdrawn.
//   - The response head transfers on a rising edge where rsp_valid && rsp_ready.
//     While rsp_valid && !rsp_ready, rsp_id/rsp_data/rsp_err are held stable.
interface cmp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*2-1:0] req_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: NREQ requesters share one W-bit subtractor-based compare
// datapath under round-robin arbitration. Each granted op is evaluated in
// the grant cycle and its result is pushed into a 2-entry response FIFO
// tagged with the requester index.
//
// Ops: 00 SLT, 01 SGT, 10 SUB, 11 SLTU.
// SLT/SGT report the sign bit of the wrapped difference (no overflow
// correction), matching the processor's existing slt/sgt units.
//
// Optional feature macro: CMP_ARB_UNSIGNED_EN
//   defined   : op 11 returns the unsigned borrow (A < B), rsp_err = 0
//   undefined : op 11 is still granted and queued, rsp_data = 0, rsp_err = 1
//
// dbg_count / dbg_ptr expose the FIFO occupancy and the round-robin pointer.
module cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    cmp_arbiter_if.slave   bus,
    output logic [1:0]     dbg_count,
    output logic [IDW-1:0] dbg_ptr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Round-robin pointer: index where the next grant search starts.
    logic [IDW-1:0] ptr;

    // FIFO occupancy, 0..2. Entry 0 lives directly in the response output
    // registers so the head holds its last value once the FIFO drains.
    logic [1:0]     count;
    logic [IDW-1:0] head_id;
    logic [W-1:0]   head_data;
    logic           head_err;
    logic [IDW-1:0] tail_id;
    logic [W-1:0]   tail_data;
    logic           tail_err;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic            pop;
    logic            can_push;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic            take;
    logic [NREQ-1:0] ready_vec;

    assign bus.rsp_valid = (count != 2'd0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    // A slot is free, or the head leaves on this same edge.
    assign can_push      = (count < 2'd2) || pop;
    // rst_n gates the grant so nothing is handed out while reset is held.
    assign take          = gnt_any && can_push && rst_n;

    // Round-robin search: start at ptr, wrap modulo NREQ, first valid lane wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[IDW-1:0];
            end
        end
    end

    // One-hot grant vector, all zero when the FIFO cannot accept a result.
    always_comb begin
        ready_vec = '0;
        if (take) begin
            ready_vec[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;

    // ------------------------------------------------------------------
    // Operand selection and compare datapath
    // ------------------------------------------------------------------
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [1:0]   sel_op;

    // Route the granted lane's operands and op into the shared datapath.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a  = bus.req_a[i*W +: W];
                sel_b  = bus.req_b[i*W +: W];
                sel_op = bus.req_op[i*2 +: 2];
            end
        end
    end

    // D = A - B (mod 2^W); SGT uses the swapped difference B - A.
    logic [W-1:0] diff_ab;
    logic [W-1:0] diff_ba;

`ifdef CMP_ARB_UNSIGNED_EN
    // Borrow out of the A - B subtraction is the unsigned A < B result.
    logic borrow;
    assign {borrow, diff_ab} = {1'b0, sel_a} - {1'b0, sel_b};
`else
    assign diff_ab = sel_a - sel_b;
`endif
    assign diff_ba = sel_b - sel_a;

    logic [W-1:0] new_data;
    logic         new_err;

    // Result formatting per op; compares are zero-extended single bits.
    always_comb begin
        new_data = '0;
        new_err  = 1'b0;
        case (sel_op)
            2'b00: new_data[0] = diff_ab[W-1];
            2'b01: new_data[0] = diff_ba[W-1];
            2'b10: new_data    = diff_ab;
            default: begin
`ifdef CMP_ARB_UNSIGNED_EN
                new_data[0] = borrow;
`else
                new_err     = 1'b1;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    // Head/tail update. Push and pop together keep the count unchanged,
    // including when full: the tail moves to the head and the new result
    // becomes the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_id   <= '0;
            head_data <= '0;
            head_err  <= 1'b0;
            tail_id   <= '0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (take) begin
                        head_id   <= gnt_idx;
                        head_data <= new_data;
                        head_err  <= new_err;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (take && pop) begin
                        head_id   <= gnt_idx;
                        head_data <= new_data;
                        head_err  <= new_err;
                    end else if (take) begin
                        tail_id   <= gnt_idx;
                        tail_data <= new_data;
                        tail_err  <= new_err;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count     <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_id   <= tail_id;
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        if (take) begin
                            tail_id   <= gnt_idx;
                            tail_data <= new_data;
                            tail_err  <= new_err;
                        end else begin
                            count     <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Advance the pointer just past the granted lane; hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign bus.rsp_id   = head_id;
    assign bus.rsp_data = head_data;
    assign bus.rsp_err  = head_err;

    assign dbg_count = count;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed scenarios plus a randomized run checked against a
// queue-based reference model of the arbiter and response FIFO.
module tb_cmp_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 1 + W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     dbg_count;
    logic [IDW-1:0] dbg_ptr;

    int checks = 0;
    int errors = 0;

    // Expected response entries, {id, err, data}, oldest first.
    logic [EW-1:0] exp_q[$];

    cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_count (dbg_count),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int lane, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[lane*W +: W]  = a;
        bus.req_b[lane*W +: W]  = b;
        bus.req_op[lane*2 +: 2] = op;
        bus.req_valid[lane]     = 1'b1;
    endtask

    // Issue one op on an otherwise idle block and sample the head one cycle later.
    task automatic issue_one(input int lane, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [NREQ-1:0] gnt, output logic rv,
                             output logic [IDW-1:0] id, output logic [W-1:0] data,
                             output logic err);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_lane(lane, op, a, b);
        #1;
        gnt = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid[lane] = 1'b0;
        @(negedge clk);
        rv   = bus.rsp_valid;
        id   = bus.rsp_id;
        data = bus.rsp_data;
        err  = bus.rsp_err;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {{(W-1){1'b0}}, 1'b1};
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return '1;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Result {err, data} from plain modular arithmetic on the operands.
    function automatic logic [W:0] model_result(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint unsigned m;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned dab;
        longint unsigned dba;
        logic [W-1:0]    data;
        logic            err;
        m    = 64'd1 << W;
        ua   = {{(64-W){1'b0}}, a};
        ub   = {{(64-W){1'b0}}, b};
        dab  = (ua + m - ub) % m;
        dba  = (ub + m - ua) % m;
        data = '0;
        err  = 1'b0;
        case (op)
            2'b00: data[0] = (dab >= m / 2);
            2'b01: data[0] = (dba >= m / 2);
            2'b10: data    = dab[W-1:0];
            default: begin
`ifdef CMP_ARB_UNSIGNED_EN
                data[0] = (ua < ub);
`else
                err     = 1'b1;
`endif
            end
        endcase
        return {err, data};
    endfunction

    // First valid lane at or after p, wrapping; -1 when none.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin errors++; $display("FAIL reset_head: got id=%0d err=%b data=%h expected all 0", bus.rsp_id, bus.rsp_err, bus.rsp_data); end
        checks++; if ({dbg_count, dbg_ptr} !== '0) begin errors++; $display("FAIL reset_state: got count=%0d ptr=%0d expected 0/0", dbg_count, dbg_ptr); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] gnt; logic rv; logic [IDW-1:0] id; logic [W-1:0] data; logic err;
        apply_reset();
        issue_one(0, 2'b00, 32'd5, 32'd9, gnt, rv, id, data, err);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL slt_grant: got %b expected 0001", gnt); end
        checks++; if ({rv, id, err, data} !== {1'b1, 2'd0, 1'b0, 32'd1}) begin errors++; $display("FAIL slt_5_9: got v=%b id=%0d err=%b data=%h expected 1/0/0/1", rv, id, err, data); end
        issue_one(0, 2'b01, 32'd5, 32'd9, gnt, rv, id, data, err);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sgt_grant: got %b expected 0001", gnt); end
        checks++; if ({rv, id, err, data} !== {1'b1, 2'd0, 1'b0, 32'd0}) begin errors++; $display("FAIL sgt_5_9: got v=%b id=%0d err=%b data=%h expected 1/0/0/0", rv, id, err, data); end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] gnt; logic rv; logic [IDW-1:0] id; logic [W-1:0] data; logic err;
        apply_reset();
        issue_one(2, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, gnt, rv, id, data, err);
        checks++; if ({gnt, rv, id, err, data} !== {4'b0100, 1'b1, 2'd2, 1'b0, 32'd1}) begin errors++; $display("FAIL slt_wrap: got gnt=%b v=%b id=%0d err=%b data=%h expected 0100/1/2/0/1", gnt, rv, id, err, data); end
        issue_one(1, 2'b10, 32'd0, 32'd1, gnt, rv, id, data, err);
        checks++; if ({gnt, rv, id, err, data} !== {4'b0010, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sub_0_1: got gnt=%b v=%b id=%0d err=%b data=%h expected 0010/1/1/0/ffffffff", gnt, rv, id, err, data); end
    endtask

    task automatic test_op11();
        logic [NREQ-1:0] gnt; logic rv; logic [IDW-1:0] id; logic [W-1:0] data; logic err;
        logic [W-1:0] exp_d; logic exp_e;
`ifdef CMP_ARB_UNSIGNED_EN
        exp_d = 32'd1; exp_e = 1'b0;
`else
        exp_d = 32'd0; exp_e = 1'b1;
`endif
        apply_reset();
        issue_one(3, 2'b11, 32'd1, 32'd2, gnt, rv, id, data, err);
        checks++; if ({gnt, rv, id} !== {4'b1000, 1'b1, 2'd3}) begin errors++; $display("FAIL op11_grant: got gnt=%b v=%b id=%0d expected 1000/1/3", gnt, rv, id); end
        checks++; if ({err, data} !== {exp_e, exp_d}) begin errors++; $display("FAIL op11_result: got err=%b data=%h expected err=%b data=%h", err, data, exp_e, exp_d); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_ready;
        apply_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_lane(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_ready = '0;
            exp_ready[c % NREQ] = 1'b1;
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rr_order c=%0d: got %b expected %b", c, bus.req_ready, exp_ready); end
            if (c > 0) begin
                checks++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'((c - 1) % NREQ)}) begin errors++; $display("FAIL rr_rsp c=%0d: got v=%b id=%0d expected 1/%0d", c, bus.rsp_valid, bus.rsp_id, (c - 1) % NREQ); end
            end
            @(posedge clk);
            #1;
            set_lane(c % NREQ, 2'($urandom_range(0, 3)), $urandom, $urandom);
            @(negedge clk);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        set_lane(1, 2'b10, 32'd100, 32'd1);
        set_lane(2, 2'b10, 32'd200, 32'd2);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_gnt1: got %b expected 0010", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid[1] = 1'b0;
        @(negedge clk); #1;
        checks++; if ({bus.req_ready, dbg_count} !== {4'b0100, 2'd1}) begin errors++; $display("FAIL bp_gnt2: got ready=%b count=%0d expected 0100/1", bus.req_ready, dbg_count); end
        @(posedge clk); #1; bus.req_valid[2] = 1'b0; set_lane(0, 2'b10, 32'd300, 32'd3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++; if ({bus.req_ready, dbg_count, dbg_ptr} !== {4'b0000, 2'd2, 2'd3}) begin errors++; $display("FAIL bp_full c=%0d: got ready=%b count=%0d ptr=%0d expected 0000/2/3", c, bus.req_ready, dbg_count, dbg_ptr); end
            checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd1, 32'd99}) begin errors++; $display("FAIL bp_head c=%0d: got v=%b id=%0d data=%h expected 1/1/63", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_pop_push: got %b expected 0001", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid[0] = 1'b0;
        @(negedge clk); #1;
        checks++; if ({dbg_count, bus.rsp_id, bus.rsp_data} !== {2'd2, 2'd2, 32'd198}) begin errors++; $display("FAIL bp_after_swap: got count=%0d id=%0d data=%h expected 2/2/c6", dbg_count, bus.rsp_id, bus.rsp_data); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if ({dbg_count, bus.rsp_id, bus.rsp_data} !== {2'd1, 2'd0, 32'd297}) begin errors++; $display("FAIL bp_drain1: got count=%0d id=%0d data=%h expected 1/0/129", dbg_count, bus.rsp_id, bus.rsp_data); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b0, 2'd0, 32'd297}) begin errors++; $display("FAIL bp_empty_hold: got v=%b id=%0d data=%h expected 0/0/129", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        set_lane(0, 2'b10, 32'd50, 32'd7);
        set_lane(1, 2'b10, 32'd60, 32'd7);
        @(posedge clk); #1; bus.req_valid[0] = 1'b0;
        @(posedge clk); #1; bus.req_valid[1] = 1'b0; set_lane(3, 2'b00, 32'd1, 32'd2);
        @(negedge clk); #1;
        checks++; if ({dbg_count, bus.rsp_data} !== {2'd2, 32'd43}) begin errors++; $display("FAIL mid_fill: got count=%0d data=%h expected 2/2b", dbg_count, bus.rsp_data); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin errors++; $display("FAIL mid_async: got ready=%b v=%b id=%0d err=%b data=%h expected all 0", bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data); end
        checks++; if ({dbg_count, dbg_ptr} !== '0) begin errors++; $display("FAIL mid_state: got count=%0d ptr=%0d expected 0/0", dbg_count, dbg_ptr); end
        set_lane(1, 2'b10, 32'd9, 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_gnt: got %b expected 0010", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = '0;
        @(negedge clk); #1;
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, dbg_count} !== {1'b1, 2'd1, 32'd5, 2'd1}) begin errors++; $display("FAIL mid_first_rsp: got v=%b id=%0d data=%h count=%0d expected 1/1/5/1", bus.rsp_valid, bus.rsp_id, bus.rsp_data, dbg_count); end
    endtask

    task automatic test_random();
        int              mptr;
        int              sz;
        int              g;
        logic            can_push;
        logic            popped;
        logic [NREQ-1:0] exp_ready;
        logic [W:0]      res;
        apply_reset();
        exp_q.delete();
        mptr = 0;
        res  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1))
                    set_lane(i, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
            end
            if (cyc >= 200 && cyc < 300) bus.rsp_ready = ($urandom_range(0, 3) == 0);
            else                         bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            sz       = exp_q.size();
            popped   = (sz > 0) && bus.rsp_ready;
            can_push = (sz < 2) || popped;
            g        = can_push ? model_pick(bus.req_valid, mptr) : -1;
            exp_ready = '0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                res = model_result(bus.req_op[g*2 +: 2], bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
            end
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, bus.req_ready, exp_ready); end
            checks++; if (bus.rsp_valid !== (sz > 0)) begin errors++; $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, bus.rsp_valid, sz > 0); end
            if (sz > 0) begin
                checks++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_data} !== exp_q[0]) begin errors++; $display("FAIL rand_head cyc=%0d: got %h expected %h", cyc, {bus.rsp_id, bus.rsp_err, bus.rsp_data}, exp_q[0]); end
            end
            checks++; if ({dbg_count, dbg_ptr} !== {2'(sz), 2'(mptr)}) begin errors++; $display("FAIL rand_state cyc=%0d: got count=%0d ptr=%0d expected %0d/%0d", cyc, dbg_count, dbg_ptr, sz, mptr); end
            @(posedge clk);
            if (popped) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back({IDW'(g), res});
                mptr = (g + 1) % NREQ;
                #1;
                bus.req_valid[g] = 1'b0;
            end
        end
        bus.req_valid = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_op11();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
